// File: rtl/nway_wb_cache.sv
// nway_wb_cache: N-way set-associative, write-back, write-allocate data cache
// for the memory stage, with per-set true-LRU replacement.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_we         CPU access strobe and store select
//   req_addr/req_wdata       byte address and right-aligned store data
//   req_funct3               access size/sign (B, H, W, BU, HU)
//   rdata                    extended load result (combinational on a hit)
//   stall                    pipeline hold; the request stays stable while high
//   mem_req/mem_we           next-level beat valid and writeback/refill select
//   mem_addr/mem_wdata       word-aligned beat address and writeback data
//   mem_ready/mem_rdata      beat accept and refill data
//   hit_cnt/miss_cnt         saturating performance counters
//
// Next-level handshake: a beat transfers on a rising edge where mem_req and
// mem_ready are both high. While mem_req is high and mem_ready is low, mem_we,
// mem_addr and mem_wdata hold their values. mem_rdata is sampled only on
// refill beats.
module nway_wb_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int BEAT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_RESUME} state_t;
  state_t state;

  // Line storage. Tags and data carry no reset; valid/dirty qualify them.
  logic [TAG_W-1:0] tag_arr  [WAYS][SETS];
  logic [31:0]      data_arr [WAYS][SETS][LINE_WORDS];
  logic [SETS-1:0]  valid_q  [WAYS];
  logic [SETS-1:0]  dirty_q  [WAYS];

  // Miss context captured when the miss is detected.
  logic [WAY_W-1:0]  vic_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  mtag_q;
  logic [BEAT_W-1:0] beat;
  logic              rerun;   // the current IDLE cycle is the post-refill replay

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [BEAT_W-1:0] req_word;

  assign req_tag  = req_addr[31 -: TAG_W];
  assign req_idx  = req_addr[2+OFF_W +: IDX_W];
  assign req_word = (LINE_WORDS == 1) ? '0 : req_addr[2 +: BEAT_W];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim;
  logic             found_inv;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_arr[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins over the LRU way.
  always_comb begin
    victim    = lru_way;
    found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[w][req_idx]) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
  end

  logic access, hit_acc, miss, store_hit, fill_we, fill_last;

  assign access    = (state == S_IDLE) && req_valid;
  assign hit_acc   = access && hit;
  assign miss      = access && !hit;
  assign store_hit = hit_acc && req_we;
  assign fill_we   = (state == S_REFILL) && mem_ready;
  assign fill_last = fill_we && (beat == LAST_BEAT);

  // Store lane selection; data is replicated so each enabled lane sees its bytes.
  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    st_be   = 4'hF;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'hF;
        st_data = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) data_arr[hit_way][req_idx][req_word][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
    if (fill_we) data_arr[vic_q][idx_q][beat] <= mem_rdata;
    if (fill_last) tag_arr[vic_q][idx_q] <= mtag_q;
  end

  // Load path
  logic [31:0] hit_word;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign hit_word = data_arr[hit_way][req_idx][req_word];
  assign ld_b     = hit_word[{req_addr[1:0], 3'b000} +: 8];
  assign ld_h     = hit_word[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    rdata = '0;
    if (hit_acc && !rst) begin
      case (req_funct3)
        3'b000:  rdata = {{24{ld_b[7]}}, ld_b};
        3'b001:  rdata = {{16{ld_h[15]}}, ld_h};
        3'b100:  rdata = {24'b0, ld_b};
        3'b101:  rdata = {16'b0, ld_h};
        default: rdata = hit_word;
      endcase
    end
  end

  assign stall = !rst && ((state != S_IDLE) || miss);

  // Next-level bus: driven straight from state so reset drops it immediately.
  logic [TAG_W-1:0] beat_tag;

  assign mem_req   = (state == S_WB) || (state == S_REFILL);
  assign mem_we    = (state == S_WB);
  assign beat_tag  = (state == S_WB) ? tag_arr[vic_q][idx_q] : mtag_q;
  assign mem_addr  = mem_req ? ((32'(beat_tag) << (32 - TAG_W)) |
                                (32'(idx_q) << (2 + OFF_W)) |
                                (32'(beat) << 2)) : '0;
  assign mem_wdata = (state == S_WB) ? data_arr[vic_q][idx_q][beat] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      beat     <= '0;
      vic_q    <= '0;
      idx_q    <= '0;
      mtag_q   <= '0;
      rerun    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          rerun <= 1'b0;
          if (hit_acc) begin
            if (req_we) dirty_q[hit_way][req_idx] <= 1'b1;
            if (!rerun && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
          end else if (miss) begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            vic_q  <= victim;
            idx_q  <= req_idx;
            mtag_q <= req_tag;
            beat   <= '0;
            state  <= (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) ? S_WB : S_REFILL;
          end
        end
        S_WB: begin
          if (mem_ready) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= S_REFILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            if (beat == LAST_BEAT) begin
              beat                  <= '0;
              valid_q[vic_q][idx_q] <= 1'b1;
              dirty_q[vic_q][idx_q] <= 1'b0;
              state                 <= S_RESUME;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: begin
          // The replayed access is a hit but must not count as one.
          rerun <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // True LRU: ages form a permutation per set; the oldest way has age WAYS-1.
  generate
    if (WAYS > 1) begin : g_lru
      logic [WAY_W-1:0] age [WAYS][SETS];
      logic             touch;
      logic [WAY_W-1:0] t_way;
      logic [IDX_W-1:0] t_set;
      logic [WAY_W-1:0] old_age;

      assign touch   = hit_acc || fill_last;
      assign t_way   = fill_last ? vic_q : hit_way;
      assign t_set   = fill_last ? idx_q : req_idx;
      assign old_age = age[t_way][t_set];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) age[w][s] <= WAY_W'(w);
          end
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == t_way) age[w][t_set] <= '0;
            else if (age[w][t_set] < old_age) age[w][t_set] <= age[w][t_set] + 1'b1;
          end
        end
      end

      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (age[w][req_idx] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
      end
    end else begin : g_no_lru
      assign lru_way = '0;
    end
  endgenerate

endmodule

// File: tb/tb_nway_wb_cache.sv
// tb_nway_wb_cache: directed and random accesses to a 2-way, 4-set,
// 4-word-line cache. The reference model tracks architectural memory, the
// next-level memory, and per-line residency/recency/dirtiness.
module tb_nway_wb_cache;

  localparam int WAYS       = 2;
  localparam int SETS       = 4;
  localparam int LINE_WORDS = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  nway_wb_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 1 KB address space = 64 lines of 16 bytes.
  logic [31:0] backing [256];   // next-level memory contents
  logic [31:0] arch    [256];   // what a load must return
  bit          resident [64];
  bit          dirty_l  [64];
  int          last_use [64];
  int          tick;
  int          m_hits, m_misses;
  logic [31:0] exp_rdata;

  // Scoreboard of expected next-level beats, in order.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_we_q[$];

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w,
                                           input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [31:0] w,
                                              input logic [31:0] d, input logic [1:0] a);
    logic [31:0] mask;
    case (f3[1:0])
      2'b00: begin
        mask = 32'hFF << (8 * a);
        return (w & ~mask) | ((d & 32'hFF) << (8 * a));
      end
      2'b01: begin
        mask = 32'hFFFF << (16 * a[1]);
        return (w & ~mask) | ((d & 32'hFFFF) << (16 * a[1]));
      end
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 64; l++) begin
      resident[l] = 0;
      dirty_l[l]  = 0;
      last_use[l] = 0;
    end
    for (int i = 0; i < 256; i++) arch[i] = backing[i];
    tick = 0; m_hits = 0; m_misses = 0;
    exp_addr_q.delete(); exp_data_q.delete(); exp_we_q.delete();
  endtask

  task automatic model_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd);
    int line, set_i, widx, cnt, vic;
    line  = int'(addr[9:4]);
    set_i = line % SETS;
    widx  = int'(addr[9:2]);
    exp_rdata = load_ext(f3, arch[widx], addr[1:0]);
    if (resident[line]) begin
      m_hits++;
    end else begin
      m_misses++;
      cnt = 0; vic = -1;
      for (int l = 0; l < 64; l++) begin
        if (resident[l] && (l % SETS == set_i)) begin
          cnt++;
          if (vic < 0 || last_use[l] < last_use[vic]) vic = l;
        end
      end
      if (cnt == WAYS) begin
        resident[vic] = 0;
        if (dirty_l[vic]) begin
          for (int k = 0; k < LINE_WORDS; k++) begin
            exp_addr_q.push_back(32'(vic * 16 + 4 * k));
            exp_data_q.push_back(arch[vic * 4 + k]);
            exp_we_q.push_back(32'd1);
          end
        end
        dirty_l[vic] = 0;
      end
      for (int k = 0; k < LINE_WORDS; k++) begin
        exp_addr_q.push_back(32'(line * 16 + 4 * k));
        exp_data_q.push_back(32'd0);
        exp_we_q.push_back(32'd0);
      end
      resident[line] = 1;
      dirty_l[line]  = 0;
    end
    tick++;
    last_use[line] = tick;
    if (we) begin
      arch[widx]    = store_merge(f3, arch[widx], wd, addr[1:0]);
      dirty_l[line] = 1;
    end
  endtask

  // Driver: one CPU access plus the next-level responder, with wlo..whi
  // cycles of mem_ready low before each beat is accepted.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int wlo, input int whi);
    int wait_left;
    bit done;
    int cyc;
    model_access(we, f3, addr, wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    wait_left = -1; done = 0; cyc = 0;
    while (!done && cyc < 300) begin
      #1;
      if (!stall) begin
        done = 1;
        mem_ready = 1'b0;
        if (!we) check("rdata", rdata, exp_rdata);
        check("beats_left", 32'(exp_addr_q.size()), 32'd0);
      end else if (mem_req) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_beat", {31'b0, mem_req}, 32'd0);
          done = 1;
          mem_ready = 1'b0;
        end else begin
          check("mem_addr", mem_addr, exp_addr_q[0]);
          check("mem_we", {31'b0, mem_we}, exp_we_q[0]);
          if (exp_we_q[0] == 32'd1) check("mem_wdata", mem_wdata, exp_data_q[0]);
          if (wait_left < 0) wait_left = int'($urandom_range(wlo, whi));
          if (wait_left > 0) begin
            mem_ready = 1'b0;
            wait_left--;
          end else begin
            mem_ready = 1'b1;
            if (mem_we) backing[mem_addr[9:2]] = mem_wdata;
            else mem_rdata = backing[mem_addr[9:2]];
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
            void'(exp_we_q.pop_front());
            wait_left = -1;
          end
        end
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) check("stall_timeout", {31'b0, stall}, 32'd0);
    req_valid = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("idle_stall", {31'b0, stall}, 32'd0);
    check("idle_rdata", rdata, 32'd0);
    check("idle_mem_req", {31'b0, mem_req}, 32'd0);
    check("hit_cnt", hit_cnt, 32'(m_hits));
    check("miss_cnt", miss_cnt, 32'(m_misses));
    exp_addr_q.delete(); exp_data_q.delete(); exp_we_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_stall"}, {31'b0, stall}, 32'd0);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_hit_cnt"}, hit_cnt, 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, 32'd0);
  endtask

  logic [2:0] ld_ops [5];
  logic [2:0] st_ops [3];

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = 3'b010; mem_ready = 1'b0; mem_rdata = '0;
    ld_ops[0] = 3'b000; ld_ops[1] = 3'b001; ld_ops[2] = 3'b010;
    ld_ops[3] = 3'b100; ld_ops[4] = 3'b101;
    st_ops[0] = 3'b000; st_ops[1] = 3'b001; st_ops[2] = 3'b010;
    for (int i = 0; i < 256; i++) backing[i] = $urandom;
    backing[16] = 32'h11; backing[17] = 32'h22; backing[18] = 32'h33; backing[19] = 32'h44;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Cold load: four refill beats 0x40..0x4C, rdata 0x11
    do_access(1'b0, 3'b010, 32'h40, 32'h0, 0, 0);

    // Byte store then signed and unsigned byte loads
    do_access(1'b1, 3'b000, 32'h41, 32'h80, 0, 0);
    do_access(1'b0, 3'b000, 32'h41, 32'h0, 0, 0);
    do_access(1'b0, 3'b100, 32'h41, 32'h0, 0, 0);
    do_access(1'b0, 3'b001, 32'h42, 32'h0, 0, 0);
    do_access(1'b0, 3'b101, 32'h40, 32'h0, 0, 0);

    // LRU: fill 0x140, touch 0x040, load 0x240 evicts 0x140; 0x040 still hits
    do_access(1'b0, 3'b010, 32'h140, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h44, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h240, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h48, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h144, 32'h0, 0, 0);

    // Dirty victim writeback
    do_access(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0);
    do_access(1'b0, 3'b010, 32'h140, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h240, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h240, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h40, 32'h0, 0, 0);

    // Slow next level: three wait cycles per beat, with and without writeback
    do_access(1'b1, 3'b001, 32'h2CA, 32'hA5A5_F00D, 3, 3);
    do_access(1'b0, 3'b010, 32'h3C8, 32'h0, 3, 3);
    do_access(1'b0, 3'b001, 32'h1CA, 32'h0, 3, 3);
    do_access(1'b0, 3'b001, 32'h2CA, 32'h0, 3, 3);

    // Random traffic over six tags per set
    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
      a  = 32'($urandom_range(0, 32'h17F));
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      do_access(we, f3, a, $urandom, 0, 2);
    end

    // Reset on the second refill beat of a miss
    begin
      int  fills;
      bit  hit_rst;
      fills = 0; hit_rst = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3C4;
      for (int c = 0; c < 100 && !hit_rst; c++) begin
        #1;
        if (mem_req && !mem_we && fills == 1) begin
          rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0; hit_rst = 1;
          #1;
          check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
          check("rst_mid_stall", {31'b0, stall}, 32'd0);
          check("rst_mid_hit_cnt", hit_cnt, 32'd0);
          check("rst_mid_miss_cnt", miss_cnt, 32'd0);
        end else begin
          if (mem_req) begin
            mem_ready = 1'b1;
            if (mem_we) begin
              backing[mem_addr[9:2]] = mem_wdata;
            end else begin
              mem_rdata = backing[mem_addr[9:2]];
              fills++;
            end
          end else begin
            mem_ready = 1'b0;
          end
          @(negedge clk);
        end
      end
      check("rst_window", 32'(hit_rst), 32'd1);
      @(negedge clk);
      #1;
      check_outputs_zero("rst_hold");
      rst = 1'b0;
      model_reset();
    end

    // Every line is invalid again: previously resident addresses miss
    do_access(1'b0, 3'b010, 32'h40, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h240, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h3C4, 32'h0, 0, 1);
    do_access(1'b0, 3'b000, 32'h43, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
